change_dispenser: RTL

- Downstream stage of the vending top level. Consumes the post-purchase balance (8-bit whole-RMB amount, same encoding as the money subtractor result) and pays it out as timed coin-eject pulses: 10-RMB coins first, then 1-RMB coins.
- Pulse timing is paced by a single-cycle tick strobe derived from the tick clock divider. Everything else runs in the system clock domain.
- Exposes the live remaining balance so the money display multiplexer can show change counting down.

---
 rtl/change_dispenser_if.sv | 39 +++
 rtl/change_dispenser.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/change_dispenser_if.sv
// ----------------------------------------------------------------------------
// change_dispenser_if
// Bundles the request/pacing inputs and the coin/status outputs of the change
// dispenser so the vending top level can hand one connection to the block.
//   master : drives tick_en, start, amount, abort; observes everything else
//   slave  : the dispenser itself
// Optional macro CHANGE_FIVE_EN adds the coin5 output.
// ----------------------------------------------------------------------------
interface change_dispenser_if;
  logic       tick_en;
  logic       start;
  logic [7:0] amount;
  logic       abort;
  logic       coin10;
  logic       coin1;
`ifdef CHANGE_FIVE_EN
  logic       coin5;
`endif
  logic       busy;
  logic       done;
  logic       aborted;
  logic [7:0] remaining;

  modport master (
    output tick_en, start, amount, abort,
`ifdef CHANGE_FIVE_EN
    input  coin5,
`endif
    input  coin10, coin1, busy, done, aborted, remaining
  );

  modport slave (
    input  tick_en, start, amount, abort,
`ifdef CHANGE_FIVE_EN
    output coin5,
`endif
    output coin10, coin1, busy, done, aborted, remaining
  );
endinterface

// File: rtl/change_dispenser.sv
// ----------------------------------------------------------------------------
// change_dispenser
// Pays out a post-purchase balance as timed coin-eject pulses: 10-RMB coins
// first, then 1-RMB coins (5-RMB in between when CHANGE_FIVE_EN is defined).
// Pulse/gap timing is counted in tick_en strobes; all logic on posedge clk.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   bus (slave)  tick_en, start, amount[7:0], abort in;
//                coin10, coin1, [coin5], busy, done, aborted, remaining[7:0] out
// Optional macro: CHANGE_FIVE_EN (adds coin5 and the 5-RMB denomination).
// ----------------------------------------------------------------------------
module change_dispenser #(
  parameter int PULSE_TICKS = 2,
  parameter int GAP_TICKS   = 1,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  change_dispenser_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEL   = 3'd1,
    S_PULSE = 3'd2,
    S_GAP   = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       denom_q;
  logic             coin10_q;
  logic             coin1_q;
`ifdef CHANGE_FIVE_EN
  logic             coin5_q;
`endif
  logic             busy_q;
  logic             done_q;
  logic             aborted_q;
  logic [7:0]       remaining_q;

  logic [CNT_W-1:0] cnt_inc_s;
  logic             pulse_end_s;
  logic             gap_end_s;

  assign cnt_inc_s   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign pulse_end_s = bus.tick_en && (cnt_inc_s == CNT_W'(PULSE_TICKS));
  assign gap_end_s   = bus.tick_en && (cnt_inc_s == CNT_W'(GAP_TICKS));

  // Payout FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      denom_q     <= 4'd0;
      coin10_q    <= 1'b0;
      coin1_q     <= 1'b0;
`ifdef CHANGE_FIVE_EN
      coin5_q     <= 1'b0;
`endif
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      remaining_q <= 8'd0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if ((state_q != S_IDLE) && bus.abort) begin
        // Abort drops any coin immediately; a truncated pulse is not charged.
        state_q  <= S_IDLE;
        coin10_q <= 1'b0;
        coin1_q  <= 1'b0;
`ifdef CHANGE_FIVE_EN
        coin5_q  <= 1'b0;
`endif
        busy_q    <= 1'b0;
        aborted_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            // Abort in the same cycle as start suppresses the request entirely.
            if (bus.start && !bus.abort) begin
              if (bus.amount != 8'd0) begin
                remaining_q <= bus.amount;
                busy_q      <= 1'b1;
                state_q     <= S_SEL;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          S_SEL: begin
            cnt_q <= '0;
            if (remaining_q >= 8'd10) begin
              denom_q  <= 4'd10;
              coin10_q <= 1'b1;
              state_q  <= S_PULSE;
`ifdef CHANGE_FIVE_EN
            end else if (remaining_q >= 8'd5) begin
              denom_q  <= 4'd5;
              coin5_q  <= 1'b1;
              state_q  <= S_PULSE;
`endif
            end else if (remaining_q != 8'd0) begin
              denom_q  <= 4'd1;
              coin1_q  <= 1'b1;
              state_q  <= S_PULSE;
            end else begin
              // done is high for the whole FIN cycle; busy drops after it.
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end
          end
          S_PULSE: begin
            if (pulse_end_s) begin
              remaining_q <= remaining_q - {4'd0, denom_q};
              coin10_q    <= 1'b0;
              coin1_q     <= 1'b0;
`ifdef CHANGE_FIVE_EN
              coin5_q     <= 1'b0;
`endif
              cnt_q       <= '0;
              state_q     <= S_GAP;
            end else if (bus.tick_en) begin
              cnt_q <= cnt_inc_s;
            end else begin
              cnt_q <= cnt_q;
            end
          end
          S_GAP: begin
            if (gap_end_s) begin
              cnt_q   <= '0;
              state_q <= S_SEL;
            end else if (bus.tick_en) begin
              cnt_q <= cnt_inc_s;
            end else begin
              cnt_q <= cnt_q;
            end
          end
          S_FIN: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: begin
            state_q  <= S_IDLE;
            coin10_q <= 1'b0;
            coin1_q  <= 1'b0;
`ifdef CHANGE_FIVE_EN
            coin5_q  <= 1'b0;
`endif
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.coin10    = coin10_q;
  assign bus.coin1     = coin1_q;
`ifdef CHANGE_FIVE_EN
  assign bus.coin5     = coin5_q;
`endif
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;
  assign bus.remaining = remaining_q;

endmodule
